// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute control FSM for the 11-bit-address CPU: owns PC and IR,
// latches datapath flags and resolves conditional jumps.
module fetch_sequencer #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               memReq,
  output logic [ADDR_W-1:0]  memAddr,
  input  logic               memAck,
  input  logic [INSTR_W-1:0] memData,
  output logic [INSTR_W-1:0] IR,
  output logic               execStart,
  input  logic               execDone,
  input  logic               ZF,
  input  logic               CF,
  output logic [ADDR_W-1:0]  PC,
  output logic               jumpTaken,
  output logic               halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    BRANCH,
    HALT
  } seqStateT;

  seqStateT state;
  seqStateT nextState;

  logic [ADDR_W-1:0]  pcReg;
  logic [INSTR_W-1:0] irReg;
  logic               zf;
  logic               cf;
  logic               isJump;
  logic               isHalt;
  logic               condTrue;

  assign isJump = (irReg[15:14] == 2'b11);
  assign isHalt = (irReg[15:11] == 5'b10111);

  // Condition evaluation only ever sees the flags latched at the last execDone.
  always_comb begin
    condTrue = 1'b0;
    unique case (irReg[13:11])
      3'b000: condTrue = 1'b1;
      3'b001: condTrue = zf;
      3'b010: condTrue = !zf;
      3'b011: condTrue = cf;
      3'b100: condTrue = !cf;
      3'b101: condTrue = !cf && !zf;
      3'b110: condTrue = cf || zf;
      3'b111: condTrue = 1'b0;
      default: condTrue = 1'b0;
    endcase
  end

  always_comb begin
    nextState = state;
    memReq    = 1'b0;
    execStart = 1'b0;
    jumpTaken = 1'b0;
    halted    = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) nextState = FETCH;
      end
      FETCH: begin
        memReq = 1'b1;
        if (memAck) nextState = DECODE;
      end
      DECODE: begin
        if (isJump) begin
          nextState = BRANCH;
        end else if (isHalt) begin
          nextState = HALT;
        end else begin
          execStart = 1'b1;
          nextState = EXEC;
        end
      end
      EXEC: begin
        if (execDone) nextState = run ? FETCH : IDLE;
      end
      BRANCH: begin
        jumpTaken = condTrue;
        nextState = run ? FETCH : IDLE;
      end
      HALT: begin
        halted = 1'b1;
        if (!run) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // PC advances on the accepted fetch and is overwritten only by a taken jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pcReg <= '0;
      irReg <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
    end else begin
      state <= nextState;
      if (state == FETCH && memAck) begin
        irReg <= memData;
        pcReg <= pcReg + 1'b1;
      end
      if (state == BRANCH && condTrue) begin
        pcReg <= irReg[ADDR_W-1:0];
      end
      if (state == EXEC && execDone) begin
        zf <= ZF;
        cf <= CF;
      end
    end
  end

  assign memAddr = pcReg;
  assign PC      = pcReg;
  assign IR      = irReg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of flag/condition jump vectors
// plus hand-written handshake, wrap, HALT and reset sequences.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        memReq;
  logic [10:0] memAddr;
  logic        memAck;
  logic [15:0] memData;
  logic [15:0] IR;
  logic        execStart;
  logic        execDone;
  logic        ZF;
  logic        CF;
  logic [10:0] PC;
  logic        jumpTaken;
  logic        halted;

  int checkCount;
  int passCount;
  logic [10:0] expPc;

  typedef struct {
    logic       z;
    logic       c;
    logic [2:0] cond;
    logic       expTaken;
  } vecT;

  vecT vecs[17];

  fetch_sequencer #(.ADDR_W(11), .INSTR_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .memReq(memReq),
    .memAddr(memAddr),
    .memAck(memAck),
    .memData(memData),
    .IR(IR),
    .execStart(execStart),
    .execDone(execDone),
    .ZF(ZF),
    .CF(CF),
    .PC(PC),
    .jumpTaken(jumpTaken),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects FETCH at expPc; holds memAck low for ackDelay cycles, then accepts.
  task automatic serveFetch(input logic [15:0] instr, input int ackDelay);
    for (int i = 0; i <= ackDelay; i++) begin
      check("fetchReq", 32'(memReq), 32'd1);
      check("fetchAddr", 32'(memAddr), 32'(expPc));
      if (i == ackDelay) begin
        memAck  = 1'b1;
        memData = instr;
      end
      tick();
      memAck  = 1'b0;
      memData = 16'h0000;
    end
    expPc = expPc + 11'd1;
    check("irLoad", 32'(IR), 32'(instr));
    check("pcInc", 32'(PC), 32'(expPc));
  endtask

  task automatic runAlu(input logic [15:0] instr, input logic z, input logic c,
                        input int ackDelay, input int doneDelay);
    int pulses;
    serveFetch(instr, ackDelay);
    pulses = 0;
    if (execStart) pulses++;
    tick();
    for (int i = 0; i < doneDelay; i++) begin
      if (execStart) pulses++;
      tick();
    end
    execDone = 1'b1;
    ZF = z;
    CF = c;
    if (execStart) pulses++;
    tick();
    execDone = 1'b0;
    ZF = 1'b0;
    CF = 1'b0;
    check("execStartPulses", 32'(pulses), 32'd1);
    check("backToFetch", 32'(memReq), 32'd1);
  endtask

  task automatic runJump(input logic [15:0] instr, input logic expTaken);
    serveFetch(instr, 0);
    check("jumpNoExecStart", 32'(execStart), 32'd0);
    tick();
    check("jumpTaken", 32'(jumpTaken), 32'(expTaken));
    tick();
    if (expTaken) expPc = instr[10:0];
    check("jumpPc", 32'(PC), 32'(expPc));
    check("jumpNextFetch", 32'(memReq), 32'd1);
    check("jumpPulseEnd", 32'(jumpTaken), 32'd0);
  endtask

  task automatic applyStimulus();
    logic [10:0] target;
    for (int i = 0; i < 17; i++) begin
      target = 11'(40 + i * 37);
      runAlu(16'h0100 + 16'(i), vecs[i].z, vecs[i].c, 0, 0);
      runJump({2'b11, vecs[i].cond, target}, vecs[i].expTaken);
    end
  endtask

  task automatic checkOutput(input string name, input logic eReq, input logic eStart,
                             input logic eJump, input logic eHalt);
    check({name, ".memReq"}, 32'(memReq), 32'(eReq));
    check({name, ".execStart"}, 32'(execStart), 32'(eStart));
    check({name, ".jumpTaken"}, 32'(jumpTaken), 32'(eJump));
    check({name, ".halted"}, 32'(halted), 32'(eHalt));
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    // z, c, cond, expected taken
    vecs[0]  = '{1'b0, 1'b0, 3'b101, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 3'b101, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b101, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 3'b101, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 3'b110, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'b110, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 3'b110, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 3'b110, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 3'b111, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b111, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'b111, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 3'b111, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 3'b000, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 3'b001, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 3'b010, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'b011, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 3'b100, 1'b0};

    rst_n = 1'b0;
    run = 1'b0;
    memAck = 1'b0;
    memData = 16'h0000;
    execDone = 1'b0;
    ZF = 1'b0;
    CF = 1'b0;
    expPc = 11'd0;
    tick();
    tick();
    check("resetPc", 32'(PC), 32'd0);
    check("resetIr", 32'(IR), 32'd0);
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    run = 1'b1;
    tick();
    check("firstReq", 32'(memReq), 32'd1);
    check("firstAddr", 32'(memAddr), 32'd0);

    $display("[TB] condition table");
    applyStimulus();

    $display("[TB] unconditional jump and PC wrap");
    runJump({2'b11, 3'b000, 11'd3}, 1'b1);
    runJump(16'hC7FF, 1'b1);
    check("pcAt2047", 32'(PC), 32'd2047);
    runAlu(16'h1234, 1'b0, 1'b0, 0, 0);
    check("pcWrapped", 32'(expPc), 32'd0);

    $display("[TB] JZ pair");
    runAlu(16'h0101, 1'b1, 1'b0, 0, 0);
    runJump(16'hC805, 1'b1);
    check("jzTakenPc", 32'(PC), 32'd5);
    runAlu(16'h0102, 1'b0, 1'b0, 0, 0);
    runJump(16'hC805, 1'b0);

    $display("[TB] delayed handshakes and stray execDone");
    runAlu(16'h0203, 1'b1, 1'b0, 3, 5);
    execDone = 1'b1;
    ZF = 1'b0;
    CF = 1'b1;
    tick();
    execDone = 1'b0;
    ZF = 1'b0;
    CF = 1'b0;
    runJump(16'hC805, 1'b1);
    runJump({2'b11, 3'b011, 11'd100}, 1'b0);

    $display("[TB] HALT");
    serveFetch(16'hB800, 0);
    check("haltNoExecStart", 32'(execStart), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("halted", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    run = 1'b0;
    tick();
    checkOutput("haltExit", 1'b0, 1'b0, 1'b0, 1'b0);
    check("haltPcKept", 32'(PC), 32'(expPc));
    run = 1'b1;
    tick();
    runAlu(16'h0304, 1'b0, 1'b0, 0, 0);

    $display("[TB] reset during fetch");
    runJump({2'b11, 3'b000, 11'd5}, 1'b1);
    check("fetchAt5", 32'(memAddr), 32'd5);
    memAck = 1'b1;
    memData = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    check("midResetPc", 32'(PC), 32'd0);
    check("midResetIr", 32'(IR), 32'd0);
    check("midResetReq", 32'(memReq), 32'd0);
    memAck = 1'b0;
    memData = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    expPc = 11'd0;
    tick();
    check("postResetReq", 32'(memReq), 32'd1);
    check("postResetAddr", 32'(memAddr), 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
